register_file_sb: RTL

Architectural integer register file with an integrated pending-write scoreboard for the RV32IM pipeline. It is the consumer end of the writeback path: it takes the selected writeback result, destination and write enable, commits them to x1–x31, and serves the two decode-stage read ports with same-cycle write-through. The scoreboard tracks destinations of long-latency M-extension ops (MUL/DIV) issued from decode and raises a decode stall on RAW/WAW hazards against them until their result is written back.

---
 rtl/rv_pkg.sv | 10 +
 rtl/register_file_sb_scoreboard.sv | 70 +++++++
 rtl/register_file_sb.sv | 68 ++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 pipeline constants: data width, register-file geometry and the
// hard-wired zero register index.
package rv_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/register_file_sb_scoreboard.sv
// Pending-write scoreboard for long-latency (MUL/DIV) destinations.
// Holds one busy bit per architectural register (x0 never busy), releases a
// register combinationally in the cycle its writeback is presented, and raises
// the decode stall on RAW/WAW hazards against still-pending registers.
module register_file_sb_scoreboard
    import rv_pkg::*;
#(
    parameter int NREG = rv_pkg::NREG,
    parameter int AW   = rv_pkg::REG_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] A1,
    input  logic [AW-1:0] A2,
    input  logic          RegWriteW,
    input  logic [AW-1:0] RdW,
    input  logic          IssueLongD,
    input  logic [AW-1:0] RdD,
    input  logic          CancelE,
    input  logic [AW-1:0] CancelRd,
    output logic          StallD
);

    localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

    logic [NREG-1:1] busy_q;
    logic [NREG-1:1] busy_d;
    logic [NREG-1:1] wb_hit;
    logic [NREG-1:1] cancel_hit;
    logic [NREG-1:0] eff_busy;
    logic            set_ok;

    // Per-register writeback/cancel decode; a writeback this cycle hides the busy bit.
    always_comb begin
        wb_hit     = '0;
        cancel_hit = '0;
        eff_busy   = '0;
        for (int r = 1; r < NREG; r++) begin
            wb_hit[r]     = RegWriteW && (RdW == AW'(r));
            cancel_hit[r] = CancelE && (CancelRd == AW'(r));
            eff_busy[r]   = busy_q[r] && !wb_hit[r];
        end
    end

    // Source reads and the decode destination both hazard against pending registers.
    assign StallD = eff_busy[A1] | eff_busy[A2] | (IssueLongD & eff_busy[RdD])
                  | ((RdD != ZERO) & eff_busy[RdD]);

    // A stalled issue must not claim its destination; x0 is never tracked.
    assign set_ok = IssueLongD && !StallD && (RdD != ZERO);

    // New ownership overrides a retiring or cancelled owner of the same register.
    always_comb begin
        busy_d = '0;
        for (int r = 1; r < NREG; r++) begin
            busy_d[r] = (set_ok && (RdD == AW'(r)))
                      || (busy_q[r] && !wb_hit[r] && !cancel_hit[r]);
        end
    end

    // Busy vector state; reset drops every pending destination at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/register_file_sb.sv
// RV32 architectural integer register file with write-through read ports and
// an integrated scoreboard that stalls decode on pending MUL/DIV results.
// x0 is not stored: it always reads zero and writes to it are dropped.
module register_file_sb
    import rv_pkg::*;
#(
    parameter int XLEN = rv_pkg::XLEN,
    parameter int NREG = rv_pkg::NREG,
    parameter int AW   = rv_pkg::REG_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    input  logic            RegWriteW,
    input  logic [AW-1:0]   RdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            IssueLongD,
    input  logic [AW-1:0]   RdD,
    input  logic            CancelE,
    input  logic [AW-1:0]   CancelRd,
    output logic            StallD
);

    localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

    logic [XLEN-1:0] regs [1:NREG-1];

    // Register array: commit the writeback result, ignoring x0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWriteW && (RdW != ZERO)) begin
            regs[RdW] <= ResultW;
        end
    end

    // Read ports: x0 reads zero, a same-cycle writeback is forwarded ahead of the array.
    assign RD1 = (A1 == ZERO)                 ? '0
               : (RegWriteW && (RdW == A1))   ? ResultW
               :                                regs[A1];

    assign RD2 = (A2 == ZERO)                 ? '0
               : (RegWriteW && (RdW == A2))   ? ResultW
               :                                regs[A2];

    register_file_sb_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .A1         (A1),
        .A2         (A2),
        .RegWriteW  (RegWriteW),
        .RdW        (RdW),
        .IssueLongD (IssueLongD),
        .RdD        (RdD),
        .CancelE    (CancelE),
        .CancelRd   (CancelRd),
        .StallD     (StallD)
    );

endmodule
